mat_tx_sequencer: RTL and testbench
===================================

Name: mat_tx_sequencer

Overview:
- Parametrised matrix-to-UART streaming sequencer; generalised successor of the matrix R dump path.
- On a start edge, walks a ROWS x COLS matrix memory in row-major or column-major order and fetches each DATA_W-bit element.
- Splits each element into bytes and hands them one at a time to the UART transmitter through a start/busy handshake.
- Optionally inserts a delimiter byte after each row (or column), then pulses done; sits between the result memory and the transmitter.

Parameters:
- ROWS, 2, matrix rows (>=1).
- COLS, 2, matrix columns (>=1).
- DATA_W, 8, element width in bits; must be a multiple of 8, range 8..32.
- ADDR_W, 8, memory address width; ROWS*COLS <= 2**ADDR_W.
- DELIM, 8'h0A, delimiter byte value.

Ports:
- slow_clk  in  1  sequencer clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level request; the rising edge is detected internally.
- col_major  in  1  traversal order, sampled at start: 0 = row-major, 1 = column-major.
- msb_first  in  1  byte order within an element, sampled at start.
- delim_en  in  1  delimiter insertion enable, sampled at start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address, r*COLS+c.
- rd_data  in  DATA_W  memory data, valid 1 cycle after rd_en.
- tx_start  out  1  one-cycle transmit request.
- tx_byte  out  8  byte to transmit.
- tx_busy  in  1  transmitter busy, from the bclk domain.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of frame.
- sent_count  out  16  bytes sent in the current/last frame, delimiters included.

Behaviour:
- Reset values: all outputs 0; state IDLE; the internal sync and edge registers are 0.
- tx_busy passes through a 2-flop synchroniser; "busy_s" below is the synchronised value.
- Start edge detection:
  - start_rise = start & ~start_q.
  - A rise while not IDLE is ignored (no queuing).
- State transitions:
  - IDLE: on start_rise, latch the mode bits, clear r, c, byte_idx and sent_count, set rd_addr = 0 -> FETCH.
  - FETCH: rd_en = 1 for exactly one cycle -> WAIT_RD.
  - WAIT_RD: capture rd_data into elem_reg at the end of this cycle -> LOAD.
  - LOAD: tx_byte = selected byte -> SEND.
    - msb_first = 1: byte index (NB-1-byte_idx).
    - msb_first = 0: byte index byte_idx.
    - NB = DATA_W/8.
  - SEND: tx_start = 1 for one cycle, tx_byte held stable; sent_count += 1 -> WAIT_HI.
  - WAIT_HI: wait for busy_s = 1 -> WAIT_LO.
    - 8-cycle timeout: if busy_s has not gone high after 8 cycles, proceed to WAIT_LO anyway.
  - WAIT_LO: wait for busy_s = 0 -> NEXT.
  - NEXT, if byte_idx < NB-1: byte_idx += 1 -> LOAD. Otherwise byte_idx = 0, advance the indices:
    - Row-major: c++ ; when c wraps to 0, r++ and end_of_line = 1.
    - Column-major: r++ ; when r wraps to 0, c++ and end_of_line = 1.
    - If end_of_line & delim_en_l -> DELIM.
    - Else if the last element has been sent -> DONE.
    - Else -> FETCH.
  - DELIM: tx_byte = DELIM -> SEND path. After WAIT_LO, return via NEXT_AFTER_DELIM:
    - last element sent -> DONE;
    - otherwise -> FETCH.
  - DONE: done = 1 for one cycle -> IDLE.
- rd_addr:
  - Updated incrementally, no multiplier.
  - Row-major: +1 per element.
  - Column-major: +COLS per element; at column wrap, set to the new c.
- sent_count holds its value in IDLE until the next start.
- Frame length = ROWS*COLS*NB + (delim_en ? lines : 0) bytes, where lines = ROWS for row-major and COLS for column-major.
- ROWS = COLS = 1: single element, then delimiter if enabled, then DONE.
- Mode inputs changing mid-frame have no effect.
- rst mid-frame: immediate return to IDLE; tx_start, rd_en and done drop asynchronously; no done pulse is generated.
- tx_busy stuck high: the block remains in WAIT_LO indefinitely; only rst recovers it.

Decomposition:
- Shared package: state encoding constants, default DELIM, the NB = DATA_W/8 helper, and the timeout constant 8.
- One natural sub-module: sync_edge, a 2-flop synchroniser plus rising-edge detector.
  - Used for tx_busy (sync only) and for start (edge detect).

Test Plan:
- ROWS=COLS=2, DATA_W=8, row-major, no delimiter, memory {11,22,33,44}:
  - bytes 11,22,33,44 in order;
  - done after the 4th byte completes;
  - sent_count = 4.
- Same memory, col_major = 1:
  - rd_addr sequence 0,2,1,3;
  - bytes 11,33,22,44.
- ROWS=2, COLS=3, delim_en = 1, row-major, memory 1..6:
  - stream 1,2,3,0A,4,5,6,0A;
  - sent_count = 8.
- DATA_W=16, element 0xA1B2:
  - msb_first = 1 -> A1,B2;
  - msb_first = 0 -> B2,A1.
- Start pulsed again mid-frame:
  - ignored; the frame completes unchanged with exactly one done pulse.
- rst asserted during WAIT_LO of the 2nd byte:
  - all outputs 0 immediately;
  - a new start produces the full frame from address 0.
- tx_busy never rises:
  - WAIT_HI times out after 8 cycles;
  - the sequence still completes.

Source files
------------

// File: rtl/mat_tx_sequencer_pkg.sv
// Shared definitions for the matrix-to-UART sequencer: state encoding,
// default delimiter, handshake timeout and element byte-count helper.
package mat_tx_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_LOAD,
        S_SEND,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT,
        S_DELIM,
        S_NEXT_AFTER_DELIM,
        S_DONE
    } state_t;

    localparam logic [7:0]  DELIM_DEFAULT  = 8'h0A;
    localparam int unsigned TIMEOUT_CYCLES = 8;

    function automatic int unsigned bytes_per_elem(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mat_tx_sequencer_sync_edge.sv
// Two-flop synchroniser; with EDGE=1 the output is a one-cycle pulse on
// the rising edge of the synchronised input, otherwise the level itself.
module mat_tx_sequencer_sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_q = EDGE ? (r_s2 & ~r_s3) : r_s2;

endmodule

// File: rtl/mat_tx_sequencer.sv
// Walks a ROWS x COLS matrix memory, splits each element into bytes and
// streams them to a UART transmitter, optionally delimiting each line.
module mat_tx_sequencer
    import mat_tx_sequencer_pkg::*;
#(
    parameter int unsigned ROWS   = 2,
    parameter int unsigned COLS   = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter logic [7:0]  DELIM  = DELIM_DEFAULT
) (
    input  logic              slow_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_major,
    input  logic              msb_first,
    input  logic              delim_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sent_count
);

    localparam int unsigned NB = bytes_per_elem(DATA_W);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [BW-1:0] NB_M1    = BW'(NB - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic [BW-1:0]       r_byte_idx;
    logic [TW-1:0]       r_to_cnt;
    logic [DATA_W-1:0]   r_elem;
    logic                r_col_major_l;
    logic                r_msb_l;
    logic                r_delim_l;
    logic                r_last_sent;
    logic                r_in_delim;
    logic [7:0]          r_tx_byte;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [15:0]         r_sent_count;

    logic                w_start_rise;
    logic                w_busy_s;
    logic                w_eol;
    logic                w_last_elem;
    logic                w_byte_last;
    logic                w_timeout;
    logic [BW-1:0]       w_byte_sel;
    logic [7:0]          w_sel_byte;

    mat_tx_sequencer_sync_edge #(.EDGE(1'b1)) u_start_edge (
        .i_clk (slow_clk),
        .i_rst (rst),
        .i_d   (start),
        .o_q   (w_start_rise)
    );

    mat_tx_sequencer_sync_edge #(.EDGE(1'b0)) u_busy_sync (
        .i_clk (slow_clk),
        .i_rst (rst),
        .i_d   (tx_busy),
        .o_q   (w_busy_s)
    );

    // End of line is known before the indices advance, so NEXT decides from current r/c.
    assign w_eol       = r_col_major_l ? (r_row == ROW_LAST) : (r_col == COL_LAST);
    assign w_last_elem = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_byte_last = (r_byte_idx == NB_M1);
    assign w_timeout   = (r_to_cnt == TO_LAST);
    assign w_byte_sel  = r_msb_l ? (NB_M1 - r_byte_idx) : r_byte_idx;

    always_comb begin
        w_sel_byte = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (w_byte_sel == BW'(i)) begin
                w_sel_byte = r_elem[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:             if (w_start_rise) w_next = S_FETCH;
            S_FETCH:            w_next = S_WAIT_RD;
            S_WAIT_RD:          w_next = S_LOAD;
            S_LOAD:             w_next = S_SEND;
            S_SEND:             w_next = S_WAIT_HI;
            S_WAIT_HI:          if (w_busy_s || w_timeout) w_next = S_WAIT_LO;
            S_WAIT_LO:          if (!w_busy_s) w_next = r_in_delim ? S_NEXT_AFTER_DELIM : S_NEXT;
            S_NEXT: begin
                if (!w_byte_last)           w_next = S_LOAD;
                else if (w_eol && r_delim_l) w_next = S_DELIM;
                else if (w_last_elem)       w_next = S_DONE;
                else                        w_next = S_FETCH;
            end
            S_DELIM:            w_next = S_SEND;
            S_NEXT_AFTER_DELIM: w_next = r_last_sent ? S_DONE : S_FETCH;
            S_DONE:             w_next = S_IDLE;
            default:            w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en    = (r_state == S_FETCH);
        tx_start = (r_state == S_SEND);
        done     = (r_state == S_DONE);
        busy     = (r_state != S_IDLE);
    end

    assign tx_byte    = r_tx_byte;
    assign rd_addr    = r_rd_addr;
    assign sent_count = r_sent_count;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_row         <= '0;
            r_col         <= '0;
            r_byte_idx    <= '0;
            r_to_cnt      <= '0;
            r_elem        <= '0;
            r_col_major_l <= 1'b0;
            r_msb_l       <= 1'b0;
            r_delim_l     <= 1'b0;
            r_last_sent   <= 1'b0;
            r_in_delim    <= 1'b0;
            r_tx_byte     <= '0;
            r_rd_addr     <= '0;
            r_sent_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        r_col_major_l <= col_major;
                        r_msb_l       <= msb_first;
                        r_delim_l     <= delim_en;
                        r_row         <= '0;
                        r_col         <= '0;
                        r_byte_idx    <= '0;
                        r_sent_count  <= '0;
                        r_rd_addr     <= '0;
                        r_last_sent   <= 1'b0;
                        r_in_delim    <= 1'b0;
                    end
                end
                S_WAIT_RD: r_elem    <= rd_data;
                S_LOAD:    r_tx_byte <= w_sel_byte;
                S_SEND: begin
                    r_sent_count <= r_sent_count + 16'd1;
                    r_to_cnt     <= '0;
                end
                S_WAIT_HI: r_to_cnt <= r_to_cnt + TW'(1);
                S_NEXT: begin
                    if (!w_byte_last) begin
                        r_byte_idx <= r_byte_idx + BW'(1);
                    end else begin
                        r_byte_idx <= '0;
                        if (w_last_elem) r_last_sent <= 1'b1;
                        // Address tracks r*COLS+c incrementally; column wrap restarts at the new column.
                        if (!r_col_major_l) begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            if (r_col == COL_LAST) begin
                                r_col <= '0;
                                r_row <= r_row + RW'(1);
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end else begin
                            if (r_row == ROW_LAST) begin
                                r_row     <= '0;
                                r_col     <= r_col + CW'(1);
                                r_rd_addr <= ADDR_W'(r_col) + ADDR_W'(1);
                            end else begin
                                r_row     <= r_row + RW'(1);
                                r_rd_addr <= r_rd_addr + ADDR_W'(COLS);
                            end
                        end
                    end
                end
                S_DELIM: begin
                    r_tx_byte  <= DELIM;
                    r_in_delim <= 1'b1;
                end
                S_NEXT_AFTER_DELIM: r_in_delim <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_tx_sequencer.sv
// Directed scoreboard bench: a 2x3 byte matrix instance and a 1x1 16-bit
// instance share a transmitter model; expected bytes/addresses are queued.
module tb_mat_tx_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, start_b = 1'b0;
    logic col_major = 1'b0, msb_first = 1'b0, delim_en = 1'b0;
    logic tx_busy;
    logic [3:0] bcnt;
    bit   no_busy = 1'b0;

    logic        rd_en_a, tx_start_a, busy_a, done_a;
    logic [7:0]  rd_addr_a, tx_byte_a, rd_data_a;
    logic [15:0] sent_a;
    logic        rd_en_b, tx_start_b, busy_b, done_b;
    logic [7:0]  rd_addr_b, tx_byte_b;
    logic [15:0] rd_data_b;
    logic [15:0] sent_b;

    logic [7:0]  mem_a [0:255];
    logic [15:0] mem_b [0:255];

    int errors = 0, checks = 0;
    int tx_cnt = 0, done_cnt = 0, cyc = 0, last_cyc = 0, gap = 0;
    int exp_len = 0, d0 = 0;
    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];

    mat_tx_sequencer #(.ROWS(2), .COLS(3), .DATA_W(8), .ADDR_W(8), .DELIM(8'h0A)) u_dut_a (
        .slow_clk(clk), .rst(rst), .start(start_a), .col_major(col_major),
        .msb_first(msb_first), .delim_en(delim_en), .rd_en(rd_en_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .tx_start(tx_start_a),
        .tx_byte(tx_byte_a), .tx_busy(tx_busy), .busy(busy_a), .done(done_a),
        .sent_count(sent_a)
    );

    mat_tx_sequencer #(.ROWS(1), .COLS(1), .DATA_W(16), .ADDR_W(8), .DELIM(8'h5A)) u_dut_b (
        .slow_clk(clk), .rst(rst), .start(start_b), .col_major(col_major),
        .msb_first(msb_first), .delim_en(delim_en), .rd_en(rd_en_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .tx_start(tx_start_b),
        .tx_byte(tx_byte_b), .tx_busy(tx_busy), .busy(busy_b), .done(done_b),
        .sent_count(sent_b)
    );

    always @(posedge clk) begin
        cyc++;
        if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
        if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
    end

    // Transmitter: busy rises the edge after tx_start and stays high six cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            bcnt    <= '0;
        end else if ((tx_start_a || tx_start_b) && !no_busy) begin
            tx_busy <= 1'b1;
            bcnt    <= 4'd6;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 4'd1;
            if (bcnt == 4'd1) tx_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_start_a || tx_start_b) begin
            tx_cnt++;
            gap      = cyc - last_cyc;
            last_cyc = cyc;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else                   e = 'x;
            check("tx_byte", tx_start_a ? tx_byte_a : tx_byte_b, e);
        end
        if (rd_en_a || rd_en_b) begin
            if (addr_q.size() != 0) e = addr_q.pop_front();
            else                    e = 'x;
            check("rd_addr", rd_en_a ? rd_addr_a : rd_addr_b, e);
        end
        if (done_a || done_b) done_cnt++;
    end

    task automatic build_exp(input bit b, input bit col, input bit msb, input bit dl);
        int a;
        logic [15:0] t;
        if (b) begin
            addr_q.push_back(8'h00);
            for (int unsigned i = 0; i < 2; i++) begin
                t = mem_b[0] >> (8 * (msb ? (1 - i) : i));
                exp_q.push_back(t[7:0]);
            end
            if (dl) exp_q.push_back(8'h5A);
        end else begin
            for (int o = 0; o < (col ? 3 : 2); o++) begin
                for (int i = 0; i < (col ? 2 : 3); i++) begin
                    a = col ? (i * 3 + o) : (o * 3 + i);
                    addr_q.push_back(a[7:0]);
                    exp_q.push_back(mem_a[a]);
                end
                if (dl) exp_q.push_back(8'h0A);
            end
        end
    endtask

    task automatic begin_frame(input bit b, input bit col, input bit msb, input bit dl);
        logic ack;
        col_major = col;
        msb_first = msb;
        delim_en  = dl;
        build_exp(b, col, msb, dl);
        exp_len = exp_q.size();
        d0      = done_cnt;
        if (b) start_b = 1'b1;
        else   start_a = 1'b1;
        ack = 1'b0;
        for (int i = 0; i < 12 && !ack; i++) begin
            @(negedge clk);
            ack = b ? busy_b : busy_a;
        end
        check("start_ack", ack, 1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic end_frame(input bit b);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = (done_cnt != d0);
        end
        check("done_seen", seen, 1);
        repeat (4) @(negedge clk);
        check("sent_count", b ? sent_b : sent_a, exp_len);
        check("bytes_left", exp_q.size(), 0);
        check("addrs_left", addr_q.size(), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("idle_busy", b ? busy_b : busy_a, 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 200 && tx_cnt < target; i++) @(negedge clk);
        check("tx_reached", tx_cnt >= target, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 16'h0000;
        end
        mem_a[0] = 8'h11; mem_a[1] = 8'h22; mem_a[2] = 8'h33;
        mem_a[3] = 8'h44; mem_a[4] = 8'h55; mem_a[5] = 8'h66;
        mem_b[0] = 16'hA1B2;

        repeat (3) @(negedge clk);
        check("reset_ctrl_a", {busy_a, tx_start_a, rd_en_a, done_a}, 0);
        check("reset_ctrl_b", {busy_b, tx_start_b, rd_en_b, done_b}, 0);
        check("reset_data_a", {rd_addr_a, tx_byte_a, sent_a}, 0);
        check("reset_data_b", {rd_addr_b, tx_byte_b, sent_b}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        begin_frame(0, 0, 0, 0); end_frame(0);   // row-major
        begin_frame(0, 1, 0, 0); end_frame(0);   // column-major
        begin_frame(0, 0, 0, 1); end_frame(0);   // row-major, delimited
        begin_frame(0, 1, 0, 1); end_frame(0);   // column-major, delimited
        begin_frame(1, 0, 1, 0); end_frame(1);   // 16-bit MSB first
        begin_frame(1, 0, 0, 1); end_frame(1);   // 16-bit LSB first, 1x1 with delimiter

        // Second start and mode changes mid-frame must not disturb the frame
        begin_frame(0, 1, 0, 1);
        wait_tx(tx_cnt + 3);
        start_a   = 1'b1;
        col_major = 1'b0;
        delim_en  = 1'b0;
        repeat (6) @(negedge clk);
        start_a = 1'b0;
        end_frame(0);

        // Reset while waiting for busy to fall after the 2nd byte
        begin_frame(0, 0, 0, 0);
        wait_tx(tx_cnt + 2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ctrl", {busy_a, tx_start_a, rd_en_a, done_a}, 0);
        check("rst_addr", rd_addr_a, 0);
        check("rst_byte", tx_byte_a, 0);
        check("rst_count", sent_a, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_done", done_cnt - d0, 0);
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge clk);
        begin_frame(0, 0, 0, 0); end_frame(0);

        // Transmitter never raises busy: each byte waits out the timeout
        no_busy = 1'b1;
        begin_frame(0, 0, 0, 0);
        end_frame(0);
        check("timeout_gap", gap, 14);
        no_busy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
